instr_encoder_loader: RTL and testbench

//  Write-side counterpart of the instruction decoder: accepts symbolic instruction

---
 rtl/instr_encoder_loader.sv | 145 ++++++++++++++
 tb/tb_instr_encoder_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic MIPS instruction tuples and streams them into instruction memory.
// Optional build macro ENC_RANGE_CHECK_EN rejects I-type immediates outside 16-bit signed range.
module instr_encoder_loader #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned MAX_WORDS = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_kind,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [31:0]       in_imm,
   input  logic [25:0]       in_target,
   input  logic              in_last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] word_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCEPT,
      S_ENCODE,
      S_WRITE,
      S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MAX_WORDS);

   state_t      state;
   logic [3:0]  k_kind;
   logic [4:0]  k_rs, k_rt, k_rd;
   logic [31:0] k_imm;
   logic [25:0] k_target;
   logic        k_last;

   logic [31:0]       enc_word;
   logic              enc_ok;
   logic              itype;
   logic              imm_ok;
   logic [ADDR_W-1:0] next_count;

   assign in_ready   = (state == S_ACCEPT);
   assign busy       = (state == S_ACCEPT) || (state == S_ENCODE) || (state == S_WRITE);
   assign done       = (state == S_DONE);
   assign next_count = word_count + 1'b1;

   always_comb begin
      enc_word = '0;
      enc_ok   = 1'b1;
      itype    = 1'b0;
      case (k_kind)
         4'd0: enc_word = {6'b000000, k_rs, k_rt, k_rd, 5'b00000, 6'b100000};
         4'd1: enc_word = {6'b000000, k_rs, k_rt, k_rd, 5'b00000, 6'b100100};
         4'd2: begin enc_word = {6'b100011, k_rs, k_rt, k_imm[15:0]}; itype = 1'b1; end
         4'd3: begin enc_word = {6'b101011, k_rs, k_rt, k_imm[15:0]}; itype = 1'b1; end
         4'd4: begin enc_word = {6'b000100, k_rs, k_rt, k_imm[15:0]}; itype = 1'b1; end
         4'd5: begin enc_word = {6'b000101, k_rs, k_rt, k_imm[15:0]}; itype = 1'b1; end
         4'd6: enc_word = {6'b000010, k_target};
         4'd7: begin enc_word = {6'b001000, k_rs, k_rt, k_imm[15:0]}; itype = 1'b1; end
         4'd8: begin enc_word = {6'b001100, k_rs, k_rt, k_imm[15:0]}; itype = 1'b1; end
         default: enc_ok = 1'b0;
      endcase
   end

`ifdef ENC_RANGE_CHECK_EN
   // Fits in 16-bit signed iff bits [31:15] are all copies of the sign bit.
   assign imm_ok = !itype || (k_imm[31:15] == '0) || (k_imm[31:15] == '1);
`else
   logic range_unused;
   assign range_unused = ^{itype, k_imm[31:16]};
   assign imm_ok       = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         mem_we     <= 1'b0;
         mem_addr   <= BASE;
         mem_wdata  <= '0;
         word_count <= '0;
         error      <= 1'b0;
         k_kind     <= '0;
         k_rs       <= '0;
         k_rt       <= '0;
         k_rd       <= '0;
         k_imm      <= '0;
         k_target   <= '0;
         k_last     <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state      <= S_ACCEPT;
                  mem_addr   <= BASE;
                  word_count <= '0;
                  error      <= 1'b0;
               end
            end
            S_ACCEPT: begin
               if (in_valid) begin
                  k_kind   <= in_kind;
                  k_rs     <= in_rs;
                  k_rt     <= in_rt;
                  k_rd     <= in_rd;
                  k_imm    <= in_imm;
                  k_target <= in_target;
                  k_last   <= in_last;
                  state    <= S_ENCODE;
               end
            end
            S_ENCODE: begin
               if (enc_ok && imm_ok) begin
                  mem_wdata <= enc_word;
                  mem_we    <= 1'b1;
                  state     <= S_WRITE;
               end else begin
                  error <= 1'b1;
                  state <= k_last ? S_DONE : S_ACCEPT;
               end
            end
            S_WRITE: begin
               mem_addr   <= mem_addr + ADDR_W'(4);
               word_count <= next_count;
               if (k_last || (next_count == LIMIT)) state <= S_DONE;
               else                                 state <= S_ACCEPT;
               if (!k_last && (next_count == LIMIT)) error <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed-vector bench for instr_encoder_loader; a second instance runs with MAX_WORDS=2.
module tb_instr_encoder_loader;

   logic        clk;
   logic        rst;
   logic        start_a, start_b;
   logic        in_valid;
   logic [3:0]  in_kind;
   logic [4:0]  in_rs, in_rt, in_rd;
   logic [31:0] in_imm;
   logic [25:0] in_target;
   logic        in_last;

   logic        a_in_ready, a_mem_we, a_busy, a_done, a_error;
   logic [7:0]  a_mem_addr, a_word_count;
   logic [31:0] a_mem_wdata;
   logic        b_in_ready, b_mem_we, b_busy, b_done, b_error;
   logic [7:0]  b_mem_addr, b_word_count;
   logic [31:0] b_mem_wdata;

   logic        sel;
   logic        s_ready, s_we, s_busy, s_done, s_error;
   logic [7:0]  s_addr, s_count;
   logic [31:0] s_data;

   int          cyc;
   int          n_vec;
   int          n_err;
   logic [7:0]  wq_addr[$];
   logic [31:0] wq_data[$];
   int          wq_cyc[$];

   instr_encoder_loader u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
      .in_target(in_target), .in_last(in_last), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
      .mem_wdata(a_mem_wdata), .busy(a_busy), .done(a_done), .error(a_error),
      .word_count(a_word_count)
   );

   instr_encoder_loader #(.MAX_WORDS(2)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
      .in_target(in_target), .in_last(in_last), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .busy(b_busy), .done(b_done), .error(b_error),
      .word_count(b_word_count)
   );

   assign s_ready = sel ? b_in_ready   : a_in_ready;
   assign s_we    = sel ? b_mem_we     : a_mem_we;
   assign s_busy  = sel ? b_busy       : a_busy;
   assign s_done  = sel ? b_done       : a_done;
   assign s_error = sel ? b_error      : a_error;
   assign s_addr  = sel ? b_mem_addr   : a_mem_addr;
   assign s_count = sel ? b_word_count : a_word_count;
   assign s_data  = sel ? b_mem_wdata  : a_mem_wdata;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (s_we === 1'b1) begin
         wq_addr.push_back(s_addr);
         wq_data.push_back(s_data);
         wq_cyc.push_back(cyc);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      wq_addr.delete();
      wq_data.delete();
      wq_cyc.delete();
   endtask

   task automatic pulse_start(input logic b);
      @(negedge clk);
      if (b) start_b = 1'b1;
      else   start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   // Called on a falling edge; returns on a falling edge.
   task automatic send(input logic [3:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] imm, input logic [25:0] target,
                       input logic last, input int bound, output logic acc, output int hs);
      acc = 1'b0;
      hs  = -1;
      in_kind = kind; in_rs = rs; in_rt = rt; in_rd = rd;
      in_imm = imm; in_target = target; in_last = last;
      in_valid = 1'b1;
      for (int i = 0; i < bound; i++) begin
         if (s_ready === 1'b1) begin
            acc = 1'b1;
            hs  = cyc;
            break;
         end
         @(negedge clk);
      end
      if (acc) begin
         @(posedge clk);
         #1 in_valid = 1'b0;
         @(negedge clk);
      end else begin
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 30; i++) begin
         if (s_done === 1'b1) break;
         @(negedge clk);
      end
      check_eq(tag, {31'd0, s_done}, 32'd1);
   endtask

   task automatic check_wr(input string tag, input int idx, input logic [7:0] addr,
                           input logic [31:0] data);
      if (idx < wq_data.size()) begin
         check_eq({tag, "_addr"}, {24'd0, wq_addr[idx]}, {24'd0, addr});
         check_eq({tag, "_data"}, wq_data[idx], data);
      end else begin
         check_eq({tag, "_present"}, 32'd0, 32'd1);
      end
   endtask

   logic acc;
   int   hs;

   initial begin
      n_vec = 0; n_err = 0; sel = 1'b0;
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0; in_valid = 1'b0;
      in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0; in_last = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_we",    {31'd0, a_mem_we},   32'd0);
      check_eq("rst_addr",  {24'd0, a_mem_addr}, 32'd0);
      check_eq("rst_count", {24'd0, a_word_count}, 32'd0);
      check_eq("rst_busy",  {31'd0, a_busy},     32'd0);
      check_eq("rst_done",  {31'd0, a_done},     32'd0);
      check_eq("rst_error", {31'd0, a_error},    32'd0);
      check_eq("rst_ready", {31'd0, a_in_ready}, 32'd0);
      rst = 1'b0;

      // ADD rs=1 rt=2 rd=3 last, with latency
      clear_log();
      pulse_start(1'b0);
      send(4'd0, 5'd1, 5'd2, 5'd3, 32'd0, 26'd0, 1'b1, 20, acc, hs);
      check_eq("t1_acc", {31'd0, acc}, 32'd1);
      wait_done("t1_done");
      check_eq("t1_nwr", wq_data.size(), 32'd1);
      check_wr("t1_w0", 0, 8'h00, 32'h00221820);
      if (wq_cyc.size() > 0) check_eq("t1_latency", wq_cyc[0] - hs, 32'd2);
      check_eq("t1_count", {24'd0, a_word_count}, 32'd1);
      check_eq("t1_error", {31'd0, a_error}, 32'd0);
      check_eq("t1_busy",  {31'd0, a_busy},  32'd0);

      // LW then BNE with negative offset
      clear_log();
      pulse_start(1'b0);
      check_eq("t2_count0", {24'd0, a_word_count}, 32'd0);
      send(4'd2, 5'd0, 5'd4, 5'd0, 32'd8, 26'd0, 1'b0, 20, acc, hs);
      send(4'd5, 5'd4, 5'd0, 5'd0, -32'sd2, 26'd0, 1'b1, 20, acc, hs);
      wait_done("t2_done");
      check_eq("t2_nwr", wq_data.size(), 32'd2);
      check_wr("t2_w0", 0, 8'h00, 32'h8C040008);
      check_wr("t2_w1", 1, 8'h04, 32'h1480FFFE);
      check_eq("t2_count", {24'd0, a_word_count}, 32'd2);

      // AND, SW, BEQ
      clear_log();
      pulse_start(1'b0);
      send(4'd1, 5'd5, 5'd6, 5'd7, 32'd0, 26'd0, 1'b0, 20, acc, hs);
      send(4'd3, 5'd29, 5'd31, 5'd0, -32'sd4, 26'd0, 1'b0, 20, acc, hs);
      send(4'd4, 5'd1, 5'd1, 5'd0, 32'd3, 26'd0, 1'b1, 20, acc, hs);
      wait_done("t3_done");
      check_eq("t3_nwr", wq_data.size(), 32'd3);
      check_wr("t3_w0", 0, 8'h00, 32'h00A63824);
      check_wr("t3_w1", 1, 8'h04, 32'hAFBFFFFC);
      check_wr("t3_w2", 2, 8'h08, 32'h10210003);

      // invalid kind then ADDI
      clear_log();
      pulse_start(1'b0);
      send(4'd15, 5'd1, 5'd1, 5'd1, 32'd1, 26'd1, 1'b0, 20, acc, hs);
      send(4'd7, 5'd0, 5'd1, 5'd0, 32'd5, 26'd0, 1'b1, 20, acc, hs);
      wait_done("t4_done");
      check_eq("t4_error", {31'd0, a_error}, 32'd1);
      check_eq("t4_nwr", wq_data.size(), 32'd1);
      check_wr("t4_w0", 0, 8'h00, 32'h20010005);
      check_eq("t4_count", {24'd0, a_word_count}, 32'd1);

      // restart clears error and address; J
      clear_log();
      pulse_start(1'b0);
      check_eq("t5_error_clr", {31'd0, a_error}, 32'd0);
      check_eq("t5_addr_base", {24'd0, a_mem_addr}, 32'd0);
      send(4'd6, 5'd0, 5'd0, 5'd0, 32'd0, 26'h000010, 1'b1, 20, acc, hs);
      wait_done("t5_done");
      check_eq("t5_nwr", wq_data.size(), 32'd1);
      check_wr("t5_w0", 0, 8'h00, 32'h08000010);

      // capacity limit on the MAX_WORDS=2 instance
      sel = 1'b1;
      clear_log();
      pulse_start(1'b1);
      send(4'd8, 5'd1, 5'd2, 5'd0, 32'h00FF, 26'd0, 1'b0, 20, acc, hs);
      send(4'd8, 5'd3, 5'd4, 5'd0, 32'h1234, 26'd0, 1'b0, 20, acc, hs);
      send(4'd8, 5'd5, 5'd6, 5'd0, 32'h0001, 26'd0, 1'b0, 20, acc, hs);
      check_eq("t6_third_acc", {31'd0, acc}, 32'd0);
      check_eq("t6_done",  {31'd0, b_done},  32'd1);
      check_eq("t6_error", {31'd0, b_error}, 32'd1);
      check_eq("t6_count", {24'd0, b_word_count}, 32'd2);
      check_eq("t6_nwr", wq_data.size(), 32'd2);
      check_wr("t6_w0", 0, 8'h00, 32'h302200FF);
      check_wr("t6_w1", 1, 8'h04, 32'h30641234);
      sel = 1'b0;

      // asynchronous reset in the middle of the second WRITE
      clear_log();
      pulse_start(1'b0);
      send(4'd2, 5'd0, 5'd4, 5'd0, 32'd8, 26'd0, 1'b0, 20, acc, hs);
      send(4'd0, 5'd1, 5'd2, 5'd3, 32'd0, 26'd0, 1'b0, 20, acc, hs);
      for (int i = 0; i < 10; i++) begin
         if (a_mem_we === 1'b1 && a_word_count == 8'd1) break;
         @(negedge clk);
      end
      check_eq("t7_in_write", {31'd0, a_mem_we}, 32'd1);
      #1 rst = 1'b1;
      #1;
      check_eq("t7_we",    {31'd0, a_mem_we},     32'd0);
      check_eq("t7_count", {24'd0, a_word_count}, 32'd0);
      check_eq("t7_addr",  {24'd0, a_mem_addr},   32'd0);
      check_eq("t7_busy",  {31'd0, a_busy},       32'd0);
      @(negedge clk);
      rst = 1'b0;

      // out-of-range immediate
      clear_log();
      pulse_start(1'b0);
      send(4'd7, 5'd0, 5'd1, 5'd0, 32'd40000, 26'd0, 1'b1, 20, acc, hs);
      wait_done("t8_done");
`ifdef ENC_RANGE_CHECK_EN
      check_eq("t8_error", {31'd0, a_error}, 32'd1);
      check_eq("t8_nwr", wq_data.size(), 32'd0);
      check_eq("t8_count", {24'd0, a_word_count}, 32'd0);
`else
      check_eq("t8_error", {31'd0, a_error}, 32'd0);
      check_eq("t8_nwr", wq_data.size(), 32'd1);
      check_wr("t8_w0", 0, 8'h00, 32'h20019C40);
      check_eq("t8_count", {24'd0, a_word_count}, 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
